// File: rtl/mem_request_arbiter_pkg.sv
// Shared constants and types for the memory request arbiter: word width,
// access-size encodings, read/write codes, FSM states and requester ids.
package mem_request_arbiter_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] GOAL_BYTE = 3'd1;
  localparam logic [2:0] GOAL_HALF = 3'd2;
  localparam logic [2:0] GOAL_WORD = 3'd4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_FET   = 2'd0,
    SRC_LOAD  = 2'd1,
    SRC_STORE = 2'd2
  } src_e;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] addr;
    logic [2:0]        goal;
    logic [WORD_W-1:0] data;
  } slot_t;

  // Unknown size codes are widened to a full word rather than passed through.
  function automatic logic [2:0] legal_goal(input logic [2:0] goal);
    case (goal)
      GOAL_BYTE, GOAL_HALF, GOAL_WORD: return goal;
      default:                         return GOAL_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_request_arbiter_pick3.sv
// Combinational three-way pick: store > load > fetch, with a starvation
// override that lets a waiting fetch jump the queue.
module arb_pick3
  import mem_request_arbiter_pkg::*;
(
  input  logic fet_valid,
  input  logic load_valid,
  input  logic store_valid,
  input  logic fet_starved,
  output logic grant,
  output src_e winner
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant  = fet_valid | load_valid | store_valid;
    winner = SRC_FET;
    if (fet_valid && fet_starved) winner = SRC_FET;
    else if (store_valid)         winner = SRC_STORE;
    else if (load_valid)          winner = SRC_LOAD;
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates fetch, load and store requests onto a single memory controller
// port, one transaction at a time, with rollback flush of speculative traffic.
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rob_rollback_in,
  input  logic              fet_request_in,
  input  logic [WORD_W-1:0] fet_address_in,
  output logic              fet_busy_out,
  output logic              fet_ready_out,
  output logic [WORD_W-1:0] fet_instruction_out,
  input  logic              lsb_load_request_in,
  input  logic [WORD_W-1:0] lsb_load_address_in,
  input  logic [2:0]        lsb_load_goal_in,
  output logic              lsb_load_busy_out,
  output logic              lsb_load_ready_out,
  output logic [WORD_W-1:0] lsb_load_data_out,
  input  logic              lsb_store_request_in,
  input  logic [WORD_W-1:0] lsb_store_address_in,
  input  logic [2:0]        lsb_store_goal_in,
  input  logic [WORD_W-1:0] lsb_store_data_in,
  output logic              lsb_store_busy_out,
  output logic              lsb_store_ready_out,
  output logic              mc_request_out,
  output logic              mc_rw_signal_out,
  output logic [WORD_W-1:0] mc_address_out,
  output logic [2:0]        mc_goal_out,
  output logic [WORD_W-1:0] mc_data_out,
  input  logic              mc_ready_in,
  input  logic [WORD_W-1:0] mc_data_in
);

  localparam logic [2:0] STARVE_LIM3 = 3'(STARVE_LIMIT);

  slot_t             fet_slot, load_slot, store_slot, pick_slot;
  arb_state_e        state, state_nx;
  src_e              win_q, pick;
  logic [2:0]        starve_cnt;
  logic              mc_rw_q;
  logic [WORD_W-1:0] mc_addr_q, mc_data_q;
  logic [2:0]        mc_goal_q;
  logic              fet_eff, load_eff, grant, issue, complete, done_cycle;

  // Rollback hides fetch/load from arbitration in the very cycle it flushes them.
  assign fet_eff    = fet_slot.valid  & ~rob_rollback_in;
  assign load_eff   = load_slot.valid & ~rob_rollback_in;
  assign done_cycle = fet_ready_out | lsb_load_ready_out | lsb_store_ready_out;

  assign fet_busy_out       = fet_slot.valid;
  assign lsb_load_busy_out  = load_slot.valid;
  assign lsb_store_busy_out = store_slot.valid;

  arb_pick3 u_pick (
    .fet_valid  (fet_eff),
    .load_valid (load_eff),
    .store_valid(store_slot.valid),
    .fet_starved(starve_cnt == STARVE_LIM3),
    .grant      (grant),
    .winner     (pick)
  );

  always_comb begin
    case (pick)
      SRC_STORE: pick_slot = store_slot;
      SRC_LOAD:  pick_slot = load_slot;
      default:   pick_slot = fet_slot;
    endcase
  end

  // The completion cycle is kept dead so a requester re-arming in it can compete.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    complete = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant && !done_cycle) begin
          issue    = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rob_rollback_in && win_q != SRC_STORE) begin
          state_nx = ST_IDLE;
        end else if (mc_ready_in) begin
          complete = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mc_request_out   = issue;
    mc_rw_signal_out = mc_rw_q;
    mc_address_out   = mc_addr_q;
    mc_goal_out      = mc_goal_q;
    mc_data_out      = mc_data_q;
    if (issue) begin
      mc_rw_signal_out = (pick == SRC_STORE) ? RW_WRITE : RW_READ;
      mc_address_out   = pick_slot.addr;
      mc_goal_out      = pick_slot.goal;
      mc_data_out      = pick_slot.data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      win_q               <= SRC_FET;
      starve_cnt          <= '0;
      fet_slot            <= '0;
      load_slot           <= '0;
      store_slot          <= '0;
      mc_rw_q             <= RW_READ;
      mc_addr_q           <= '0;
      mc_goal_q           <= '0;
      mc_data_q           <= '0;
      fet_ready_out       <= 1'b0;
      lsb_load_ready_out  <= 1'b0;
      lsb_store_ready_out <= 1'b0;
      fet_instruction_out <= '0;
      lsb_load_data_out   <= '0;
    end else begin
      state               <= state_nx;
      fet_ready_out       <= complete && win_q == SRC_FET;
      lsb_load_ready_out  <= complete && win_q == SRC_LOAD;
      lsb_store_ready_out <= complete && win_q == SRC_STORE;

      if (issue) begin
        win_q     <= pick;
        mc_rw_q   <= mc_rw_signal_out;
        mc_addr_q <= pick_slot.addr;
        mc_goal_q <= pick_slot.goal;
        mc_data_q <= pick_slot.data;
        if (pick == SRC_FET)                    starve_cnt <= '0;
        else if (fet_eff && starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
      end

      if (complete && win_q == SRC_FET)  fet_instruction_out <= mc_data_in;
      if (complete && win_q == SRC_LOAD) lsb_load_data_out   <= mc_data_in;

      if (rob_rollback_in || (complete && win_q == SRC_FET)) fet_slot.valid <= 1'b0;
      else if (fet_request_in && !fet_slot.valid)
        fet_slot <= '{valid: 1'b1, addr: fet_address_in, goal: GOAL_WORD, data: '0};

      if (rob_rollback_in || (complete && win_q == SRC_LOAD)) load_slot.valid <= 1'b0;
      else if (lsb_load_request_in && !load_slot.valid)
        load_slot <= '{valid: 1'b1, addr: lsb_load_address_in,
                       goal: legal_goal(lsb_load_goal_in), data: '0};

      if (complete && win_q == SRC_STORE) store_slot.valid <= 1'b0;
      else if (lsb_store_request_in && !store_slot.valid)
        store_slot <= '{valid: 1'b1, addr: lsb_store_address_in,
                        goal: legal_goal(lsb_store_goal_in), data: lsb_store_data_in};
    end
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, is the number of consecutive load/store grants after which a pending fetch wins.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rob_rollback_in  in  1  flush of speculative fetch/load traffic.
REQ-005 fet_request_in / fet_address_in[31:0]  in  fetch request pulse and byte address; fetch size is fixed at 4 bytes.
REQ-006 fet_busy_out  out  1  fetch slot occupied; fet_ready_out out 1 completion pulse; fet_instruction_out out 32 fetched word.
REQ-007 lsb_load_request_in / lsb_load_address_in[31:0] / lsb_load_goal_in[2:0]  in  load request; goal is 1, 2 or 4 bytes.
REQ-008 lsb_load_busy_out  out  1; lsb_load_ready_out  out  1; lsb_load_data_out  out  32.
REQ-009 lsb_store_request_in / lsb_store_address_in[31:0] / lsb_store_goal_in[2:0] / lsb_store_data_in[31:0]  in  store request.
REQ-010 lsb_store_busy_out  out  1; lsb_store_ready_out  out  1  store completion pulse.
REQ-011 mc_request_out  out  1  one-cycle issue pulse to the memory controller; mc_rw_signal_out out 1 (1 = write); mc_address_out out 32; mc_goal_out out 3; mc_data_out out 32.
REQ-012 mc_ready_in  in  1  completion pulse from the memory controller; mc_data_in  in  32  read data, valid with mc_ready_in.

Function
REQ-013 There SHALL be one holding slot per requester (fetch, load, store); a request is accepted when its request_in is 1 and its busy_out is 0.
REQ-014 An accepted request SHALL be captured into its slot, and busy_out SHALL rise the next cycle and stay high until the cycle its ready_out pulses.
REQ-015 A request_in asserted while busy_out is 1 SHALL be ignored.
REQ-016 The FSM SHALL have two states, IDLE and WAIT.
REQ-017 In IDLE with at least one slot valid, the arbiter SHALL pick a winner, drive mc_request_out = 1 for exactly one cycle with the winner's rw/address/goal/data, and enter WAIT.
REQ-018 Priority SHALL be store > load > fetch, except that fetch wins when starve_cnt = STARVE_LIMIT.
REQ-019 starve_cnt (3 bits, saturating) SHALL increment on each load/store grant made while the fetch slot is valid, and clear on each fetch grant.
REQ-020 In WAIT, on mc_ready_in = 1, the arbiter SHALL clear the winner's slot, pulse its ready_out for one cycle on the next cycle, register mc_data_in to its data output (load/fetch only), and return to IDLE.
REQ-021 The earliest next issue SHALL be the cycle after the ready_out pulse, giving one dead cycle between transactions.
REQ-022 The mc_* fields SHALL hold their values during WAIT.
REQ-023 A slot request arriving in the same cycle as IDLE arbitration SHALL NOT compete until the following cycle.
REQ-024 On rob_rollback_in = 1, the arbiter SHALL clear the fetch and load slots, and fetch/load requests in that cycle SHALL be ignored.
REQ-025 On rob_rollback_in = 1, the store slot and any store request in that cycle SHALL be preserved.
REQ-026 Rollback in WAIT with a fetch/load winner SHALL force IDLE the next cycle with no ready_out; an mc_ready_in in that same cycle SHALL be discarded.
REQ-027 Rollback in WAIT with a store winner SHALL have no effect on that transaction.
REQ-028 An mc_ready_in arriving while in IDLE SHALL be ignored.

Reset
REQ-029 While rst_n = 0, the FSM SHALL be in IDLE, all slots invalid, and starve_cnt = 0.
REQ-030 While rst_n = 0, all *_ready_out, *_busy_out and mc_request_out SHALL be 0, and all data/address outputs 32'h0.
REQ-031 Reset asserted mid-transaction SHALL abandon that transaction with no completion pulse after release.

Structure
REQ-032 Word width, goal encodings (1/2/4), READ/WRITE values and the FSM state encodings SHALL live in the shared header.v constants.
REQ-033 The fixed-priority-with-override pick SHALL be one combinational sub-module, arb_pick3.

Verification
REQ-034 Fetch 0x1000 alone -> mc_request_out pulses one cycle with rw = 0, goal = 4; mc_ready_in with data 0xDEADBEEF -> fet_ready_out pulses the next cycle with fet_instruction_out = 0xDEADBEEF.
REQ-035 Fetch, load and store accepted in the same cycle -> issue order is store, load, fetch, with one dead cycle after each completion.
REQ-036 Fetch pending plus continuous load traffic with STARVE_LIMIT = 4 -> after the 4th load grant, fetch is issued next.
REQ-037 Rollback during WAIT on a load 0x2000 -> no lsb_load_ready_out, IDLE next cycle, and the held store slot is issued next.
REQ-038 Store 0x3000/0x12345678 with goal 4, then rollback during WAIT -> lsb_store_ready_out still pulses after mc_ready_in.
REQ-039 rst_n = 0 during WAIT -> all outputs 0 asynchronously; the late mc_ready_in after release produces no ready pulse.
